// File: rtl/rv32i_pkg.sv
// +-----------------------------------------------------------------------+
// | rv32i_pkg : shared constants and types for the RV32I core             |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package rv32i_pkg;

  localparam int          ILEN        = 32;
  localparam logic [31:0] RV_NOP      = 32'h0000_0013;
  localparam logic [31:0] RV_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_pc_gen.sv
// +-----------------------------------------------------------------------+
// | fetch_pc_gen : program counter with pc+4 / aligned-redirect next-PC   |
// | mux and redirect misalignment flag.  Rev 1.0                          |
// +-----------------------------------------------------------------------+
`default_nettype none

module fetch_pc_gen
  import rv32i_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RV_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_retire,
  input  logic              i_redirect_valid,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_misalign
);

  logic [ADDR_W-1:0] r_pc;
  logic              r_misalign;
  logic [ADDR_W-1:0] w_next_pc;
  logic              w_misalign;

  // Redirect targets are forced to a word boundary; the low bits only raise a flag.
  always_comb begin
    w_next_pc  = r_pc + ADDR_W'(4);
    w_misalign = 1'b0;
    if (i_redirect_valid) begin
      w_next_pc  = {i_redirect_pc[ADDR_W-1:2], 2'b00};
      w_misalign = |i_redirect_pc[1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= i_retire & w_misalign;
      if (i_retire) begin
        r_pc <= w_next_pc;
      end
    end
  end

  assign o_pc       = r_pc;
  assign o_misalign = r_misalign;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// +-----------------------------------------------------------------------+
// | fetch_stage : RV32I instruction fetch (req/gnt/rvalid imem port).     |
// | FETCH_PERF_CNT_EN adds retire / wait-cycle counters.  Rev 1.0         |
// +-----------------------------------------------------------------------+
`default_nettype none

module fetch_stage
  import rv32i_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RV_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [ILEN-1:0]   imem_rdata,
  output logic [ILEN-1:0]   instr,
  output logic [ADDR_W-1:0] pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              fetch_misalign
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_retired,
  output logic [31:0]       perf_wait_cycles
`endif
);

  fetch_state_t      r_state;
  fetch_state_t      w_state_next;
  logic [ILEN-1:0]   r_instr;
  logic              r_instr_valid;
  logic              w_retire;
  logic              w_rsp;
  logic              w_imem_req;
  logic [ADDR_W-1:0] w_pc;

  assign w_retire = (r_state == S_HOLD) & r_instr_valid & instr_ready;
  assign w_rsp    = (r_state == S_WAIT) & imem_rvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  w_state_next = S_REQ;
      S_REQ:   if (imem_gnt) w_state_next = S_WAIT;
      S_WAIT:  if (imem_rvalid) w_state_next = S_HOLD;
      S_HOLD:  if (w_retire) w_state_next = S_REQ;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_imem_req = 1'b0;
    case (r_state)
      S_REQ:   w_imem_req = 1'b1;
      default: w_imem_req = 1'b0;
    endcase
  end

  // Instruction register only ever loads from an in-state response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr       <= RV_NOP;
      r_instr_valid <= 1'b0;
    end else begin
      if (w_rsp) begin
        r_instr       <= imem_rdata;
        r_instr_valid <= 1'b1;
      end else if (w_retire) begin
        r_instr_valid <= 1'b0;
      end
    end
  end

  fetch_pc_gen #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_retire         (w_retire),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_pc             (w_pc),
    .o_misalign       (fetch_misalign)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_retired;
  logic [31:0] r_perf_wait;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_retired <= '0;
      r_perf_wait    <= '0;
    end else begin
      if (w_retire) begin
        r_perf_retired <= r_perf_retired + 32'd1;
      end
      if ((r_state == S_REQ) || (r_state == S_WAIT)) begin
        r_perf_wait <= r_perf_wait + 32'd1;
      end
    end
  end

  assign perf_retired     = r_perf_retired;
  assign perf_wait_cycles = r_perf_wait;
`endif

  assign imem_req    = w_imem_req;
  assign imem_addr   = w_pc;
  assign pc          = w_pc;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// +-----------------------------------------------------------------------+
// | tb_fetch_stage : directed self-checking bench for fetch_stage         |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_misalign;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_retired;
  logic [31:0] perf_wait_cycles;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_stage #(
    .ADDR_W   (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr          (instr),
    .pc             (pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_misalign (fetch_misalign)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_retired     (perf_retired),
    .perf_wait_cycles (perf_wait_cycles)
`endif
  );

  // Memory contents: word at address a is a ^ 00500093 (word 0 = addi x1,x0,5).
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h0050_0093;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_fetch(input int gnt_delay);
    logic [31:0] a;
    imem_gnt = 1'b0;
    repeat (gnt_delay) tick();
    imem_gnt = 1'b1;
    a = imem_addr;
    tick();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = mem_word(a);
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
  endtask

  task automatic retire(input logic rv, input logic [31:0] rpc);
    instr_ready    = 1'b1;
    redirect_valid = rv;
    redirect_pc    = rpc;
    tick();
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    repeat (2) tick();
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got %b exp 0", imem_req); end
    n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr got %h exp 0", imem_addr); end
    n_vec++; if (instr !== 32'h0000_0013) begin n_err++; $display("FAIL rst_instr got %h exp 00000013", instr); end
    n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", instr_valid); end
    n_vec++; if (fetch_misalign !== 1'b0) begin n_err++; $display("FAIL rst_misalign got %b exp 0", fetch_misalign); end
`ifdef FETCH_PERF_CNT_EN
    n_vec++; if (perf_retired !== 32'h0 || perf_wait_cycles !== 32'h0) begin
      n_err++; $display("FAIL rst_perf got %h/%h exp 0/0", perf_retired, perf_wait_cycles); end
`endif
    rst_n = 1'b1;
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL idle_req got %b exp 0", imem_req); end
    tick();
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_err++; $display("FAIL first_req got req=%b addr=%h exp req=1 addr=0", imem_req, imem_addr); end
    drive_fetch(0);
    n_vec++; if (instr_valid !== 1'b1 || instr !== 32'h0050_0093 || pc !== 32'h0) begin
      n_err++; $display("FAIL first_instr got v=%b i=%h pc=%h exp v=1 i=00500093 pc=0", instr_valid, instr, pc); end
  endtask

  task automatic test_sequential();
    for (int i = 1; i <= 3; i++) begin
      retire(1'b0, 32'h0);
      n_vec++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'(4 * i)) begin
        n_err++; $display("FAIL seq_issue got v=%b req=%b addr=%h exp v=0 req=1 addr=%h",
                          instr_valid, imem_req, imem_addr, 32'(4 * i)); end
      drive_fetch(0);
      n_vec++; if (instr_valid !== 1'b1 || instr !== mem_word(32'(4 * i)) || pc !== 32'(4 * i)) begin
        n_err++; $display("FAIL seq_instr got v=%b i=%h pc=%h exp v=1 i=%h pc=%h",
                          instr_valid, instr, pc, mem_word(32'(4 * i)), 32'(4 * i)); end
    end
  endtask

  task automatic test_redirect();
    retire(1'b1, 32'h0000_0008);
    n_vec++; if (imem_addr !== 32'h8 || fetch_misalign !== 1'b0) begin
      n_err++; $display("FAIL redir8 got addr=%h mis=%b exp addr=8 mis=0", imem_addr, fetch_misalign); end
    drive_fetch(0);
    n_vec++; if (pc !== 32'h8 || instr !== mem_word(32'h8)) begin
      n_err++; $display("FAIL redir8_instr got pc=%h i=%h exp pc=8 i=%h", pc, instr, mem_word(32'h8)); end
    retire(1'b1, 32'h0000_0100);
    n_vec++; if (imem_addr !== 32'h100 || pc !== 32'h100 || fetch_misalign !== 1'b0) begin
      n_err++; $display("FAIL redir100 got addr=%h pc=%h mis=%b exp 100/100/0", imem_addr, pc, fetch_misalign); end
    drive_fetch(0);
    n_vec++; if (instr !== mem_word(32'h100)) begin
      n_err++; $display("FAIL redir100_instr got %h exp %h", instr, mem_word(32'h100)); end
    retire(1'b1, 32'h0000_0102);
    n_vec++; if (imem_addr !== 32'h100 || fetch_misalign !== 1'b1) begin
      n_err++; $display("FAIL redir102 got addr=%h mis=%b exp addr=100 mis=1", imem_addr, fetch_misalign); end
    tick();
    n_vec++; if (fetch_misalign !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      n_err++; $display("FAIL mis_pulse got mis=%b req=%b addr=%h exp 0/1/100", fetch_misalign, imem_req, imem_addr); end
    drive_fetch(0);
  endtask

  task automatic test_stall();
    retire(1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h104) begin
        n_err++; $display("FAIL gnt_stall[%0d] got req=%b addr=%h exp req=1 addr=104", i, imem_req, imem_addr); end
      tick();
    end
    drive_fetch(0);
    instr_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++; if (instr !== mem_word(32'h104) || pc !== 32'h104 || instr_valid !== 1'b1 || imem_req !== 1'b0) begin
        n_err++; $display("FAIL backpressure[%0d] got i=%h pc=%h v=%b req=%b exp i=%h pc=104 v=1 req=0",
                          i, instr, pc, instr_valid, imem_req, mem_word(32'h104)); end
    end
    redirect_valid = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    retire(1'b0, 32'h0);
    n_vec++; if (imem_addr !== 32'h108) begin
      n_err++; $display("FAIL redir_ignored got addr=%h exp 108", imem_addr); end
  endtask

  task automatic test_reset_midflight();
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    n_vec++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || pc !== 32'h0 ||
                 instr !== 32'h0000_0013 || instr_valid !== 1'b0) begin
      n_err++; $display("FAIL async_rst got req=%b addr=%h pc=%h i=%h v=%b exp 0/0/0/00000013/0",
                        imem_req, imem_addr, pc, instr, instr_valid); end
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    rst_n = 1'b1;
    tick();
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    n_vec++; if (instr !== 32'h0000_0013 || instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_err++; $display("FAIL late_rvalid got i=%h v=%b req=%b addr=%h exp 00000013/0/1/0",
                        instr, instr_valid, imem_req, imem_addr); end
  endtask

  task automatic test_wrap();
    drive_fetch(0);
    n_vec++; if (instr !== mem_word(32'h0) || pc !== 32'h0 || instr_valid !== 1'b1) begin
      n_err++; $display("FAIL restart got i=%h pc=%h v=%b exp %h/0/1", instr, pc, instr_valid, mem_word(32'h0)); end
    retire(1'b1, 32'hFFFF_FFFC);
    n_vec++; if (imem_addr !== 32'hFFFF_FFFC) begin
      n_err++; $display("FAIL top_addr got %h exp fffffffc", imem_addr); end
    drive_fetch(0);
    n_vec++; if (pc !== 32'hFFFF_FFFC || instr !== mem_word(32'hFFFF_FFFC)) begin
      n_err++; $display("FAIL top_instr got pc=%h i=%h exp fffffffc/%h", pc, instr, mem_word(32'hFFFF_FFFC)); end
    retire(1'b0, 32'h0);
    n_vec++; if (imem_addr !== 32'h0 || pc !== 32'h0) begin
      n_err++; $display("FAIL wrap got addr=%h pc=%h exp 0/0", imem_addr, pc); end
`ifdef FETCH_PERF_CNT_EN
    n_vec++; if (perf_retired !== 32'd2 || perf_wait_cycles !== 32'd4) begin
      n_err++; $display("FAIL perf got ret=%0d wait=%0d exp 2/4", perf_retired, perf_wait_cycles); end
`endif
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_redirect();
    test_stall();
    test_reset_midflight();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
